// File: rtl/pmu_lpmd_seq_c910.sv
// rtl/pmu_lpmd_seq_c910.sv - low-power-mode sequencer: idle wait, core clock gating, wake pulse, settle delay
//
// Optional feature macro: PMU_DBG_WAKEUP_EN (when defined, dbg_wake_req is a wake source)
//
// Ports:
//   fast_clk          in   sequencer clock
//   pad_cpu_rst_b     in   asynchronous active-low reset
//   cpu_pmu_lpmd_b    in   [1:0] low-power request (11 run, 10 wait, 00 stop, 01 treated as run)
//   cpu_pmu_idle      in   core pipeline and bus quiescent
//   intr_wake_req     in   level wake request from the interrupt controller
//   dbg_wake_req      in   level wake request from the debug module
//   pmu_cpu_clk_en    out  core clock enable
//   pmu_cpu_lpmd_ack  out  one-cycle acknowledge that the clock is gated
//   pmu_wake_pulse    out  one-cycle wake event for the fast-to-slow synchronizer
//   pmu_stop_mode     out  high while gated in stop mode
//   pmu_state         out  [2:0] current FSM state

module pmu_lpmd_seq_c910 #(
    parameter int SETTLE_CYC = 8
) (
    input  logic       fast_clk,
    input  logic       pad_cpu_rst_b,
    input  logic [1:0] cpu_pmu_lpmd_b,
    input  logic       cpu_pmu_idle,
    input  logic       intr_wake_req,
    input  logic       dbg_wake_req,
    output logic       pmu_cpu_clk_en,
    output logic       pmu_cpu_lpmd_ack,
    output logic       pmu_wake_pulse,
    output logic       pmu_stop_mode,
    output logic [2:0] pmu_state
);

    localparam logic [2:0] ST_RUN       = 3'd0;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd1;
    localparam logic [2:0] ST_GATE      = 3'd2;
    localparam logic [2:0] ST_SLEEP     = 3'd3;
    localparam logic [2:0] ST_WAKE      = 3'd4;
    localparam logic [2:0] ST_SETTLE    = 3'd5;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    logic [2:0] state;
    logic [2:0] next_state;
    logic       stop_q;
    logic       stop_d;
    logic [3:0] cnt;
    logic [3:0] cnt_d;
    logic       clk_en_d;
    logic       ack_d;
    logic       pulse_d;
    logic       stop_mode_d;
    logic       wk;
    logic       lpm_req;

`ifdef PMU_DBG_WAKEUP_EN
    assign wk = intr_wake_req | dbg_wake_req;
`else
    logic unused_dbg_wake_req;
    assign unused_dbg_wake_req = dbg_wake_req;
    assign wk = intr_wake_req;
`endif

    // 2'b01 is reserved and behaves as run, so only 10 and 00 request entry
    assign lpm_req = (cpu_pmu_lpmd_b == 2'b10) || (cpu_pmu_lpmd_b == 2'b00);

    always_ff @(posedge fast_clk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            state            <= ST_RUN;
            stop_q           <= 1'b0;
            cnt              <= 4'd0;
            pmu_cpu_clk_en   <= 1'b1;
            pmu_cpu_lpmd_ack <= 1'b0;
            pmu_wake_pulse   <= 1'b0;
            pmu_stop_mode    <= 1'b0;
        end else begin
            state            <= next_state;
            stop_q           <= stop_d;
            cnt              <= cnt_d;
            pmu_cpu_clk_en   <= clk_en_d;
            pmu_cpu_lpmd_ack <= ack_d;
            pmu_wake_pulse   <= pulse_d;
            pmu_stop_mode    <= stop_mode_d;
        end
    end

    always_comb begin
        next_state = ST_RUN;
        case (state)
            ST_RUN:       next_state = lpm_req ? ST_WAIT_IDLE : ST_RUN;
            // abort takes priority over idle so a pending wake never gets gated
            ST_WAIT_IDLE: next_state = wk ? ST_RUN : (cpu_pmu_idle ? ST_GATE : ST_WAIT_IDLE);
            ST_GATE:      next_state = ST_SLEEP;
            ST_SLEEP:     next_state = wk ? ST_WAKE : ST_SLEEP;
            ST_WAKE:      next_state = ST_SETTLE;
            ST_SETTLE:    next_state = (cnt == 4'd0) ? ST_RUN : ST_SETTLE;
            default:      next_state = ST_RUN;
        endcase
    end

    // Registered outputs: ack/pulse/clk_en follow the current state one cycle
    // later; stop_mode is taken from next_state so it lines up with pmu_state.
    always_comb begin
        stop_d   = stop_q;
        cnt_d    = cnt;
        clk_en_d = pmu_cpu_clk_en;
        ack_d    = 1'b0;
        pulse_d  = 1'b0;
        case (state)
            ST_RUN: begin
                clk_en_d = 1'b1;
                if (lpm_req) begin
                    stop_d = (cpu_pmu_lpmd_b == 2'b00);
                end
            end
            ST_WAIT_IDLE: clk_en_d = 1'b1;
            ST_GATE: begin
                clk_en_d = 1'b0;
                ack_d    = 1'b1;
            end
            ST_SLEEP: clk_en_d = 1'b0;
            ST_WAKE: begin
                pulse_d = 1'b1;
                cnt_d   = SETTLE_LOAD;
            end
            ST_SETTLE: begin
                if (cnt == 4'd0) begin
                    clk_en_d = 1'b1;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            default: clk_en_d = 1'b1;
        endcase
        stop_mode_d = stop_d && ((next_state == ST_SLEEP) || (next_state == ST_WAKE) ||
                                 (next_state == ST_SETTLE));
    end

    assign pmu_state = state;

endmodule
